varredura_matriz: RTL and testbench
===================================

// Module: varredura_matriz
// PURPOSE
//  Column-scan driver for the 7x5 LED matrix. Consumes the five 7-bit column patterns from the game selector.
//  Drives one column at a time with a blanking gap between slots to suppress ghosting.
//  Captures a new frame only at frame boundaries, and only when the inputs have been stable. No tearing.
//  Last stage before the board pins.
// PARAMETERS
//  SCAN_DIV      50000  clk cycles per column slot (50 MHz -> 1 kHz/column, 200 Hz frame); >= BLANK_CYCLES+1
//  BLANK_CYCLES  500    cycles at start of each slot with all columns off
//  DIV_W         16     prescaler width; 2**DIV_W >= SCAN_DIV
//  BLINK_FRAMES  50     frames per blink half-period (only with BLINK_EN)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  reset, asynchronous assert, active-low
//  coluna1..5   in   7  column patterns from selector; async to clk, bit i = row i
//  piscar       in   1  blink request (ignored unless BLINK_EN)
//  col_n        out  5  column enables, active-low one-hot; 5'b11111 = all off
//  linhas       out  7  row data for the active column, same polarity as coluna inputs
//  frame_tick   out  1  1-cycle pulse on last cycle of column-5 slot
// BEHAVIOUR
//  Reset: cnt=0, idx=0, shadow=0, samples=0, col_n=5'b11111, linhas=7'd0, frame_tick=0, blink state=0.
//  Prescaler cnt runs 0..SCAN_DIV-1. On wrap, idx increments 0..4 and wraps to 0.
//  Outputs are decoded only from registers. There is no combinational path from any input to any output.
//  Slot rule: cnt < BLANK_CYCLES -> col_n=11111, linhas=0. Otherwise col_n=~(1<<idx), linhas=shadow[idx].
//  Input capture: each cycle s1<={coluna5..coluna1}, s2<=s1 (35-bit). stable = (s1==s2).
//  Frame boundary is idx==4 && cnt==SCAN_DIV-1.
//   - There: frame_tick=1. If stable, shadow<=s2; else keep old shadow and retry at the next boundary.
//  New shadow is first visible in column 1 of the next frame, after its blanking gap.
//  Simultaneous input change and boundary: stable=0, so the load is skipped. Never a partial frame.
//  Reset mid-scan: immediate all-off and shadow cleared. Scan restarts at column 1, slot start.
//  First lit column after reset release: col_n=5'b11110 from cycle BLANK_CYCLES, counting from the first edge as cycle 0.
//  Blanking starts every slot. There is never an overlap of two active columns.
// CONFIGURATION
//  `BLINK_EN defined:
//   - frame counter fcnt counts 0..BLINK_FRAMES-1 on frame_tick; on wrap it toggles phase.
//   - While piscar=1 and phase=1, col_n=11111 and linhas=0 for whole slots.
//   - piscar is sampled (2-flop) and its changes take effect at the next slot start only.
//   - piscar=0 forces phase=0 at the next frame_tick.
//  `BLINK_EN undefined: piscar unused, no fcnt/phase logic, display always scanned.
// STRUCTURE
//  Shared package/header: N_COL=5, N_ROW=7, COL_OFF=5'b11111, frame type [N_COL*N_ROW-1:0].
//  Single module. The prescaler+idx counter is one always block. No sub-module is needed.
// TESTING  (bench: SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2)
//  1 Reset, inputs 0 -> col_n=11111, linhas=0 during reset. After release, col_n sequence per slot is:
//    11111 x2, then 11110 x6, then 11111 x2, then 11101 x6 ... with period 40 cycles.
//  2 Apply 0111100,0011101,0110101,1000111,1110111, held stable.
//    frame_tick at cycle 39. Next frame slot k shows the k-th pattern on linhas; slot 1 shows linhas=0111100 while col_n=11110.
//  3 Change coluna3 on the cycle before the boundary -> shadow unchanged for that frame.
//    Loaded at the following boundary and visible one frame later.
//  4 Assert rst_n=0 during slot 3 -> col_n=11111 and linhas=0 asynchronously. After release, the scan restarts at column 1.
//  5 Check at every cycle: col_n has at most one 0; linhas=0 whenever col_n=11111.
//  6 (BLINK_EN) piscar=1 -> 2 frames lit, 2 frames dark, repeating.
//    piscar=0 -> display continuously lit from the next frame boundary.

Source files
------------

// File: rtl/varredura_matriz_pkg.sv
// Shared constants and types for the 7x5 LED matrix column-scan driver.
package varredura_matriz_pkg;

  localparam int N_COL = 5;
  localparam int N_ROW = 7;
  localparam logic [N_COL-1:0] COL_OFF = 5'b11111;

  typedef logic [N_COL*N_ROW-1:0] frame_t;

  // Active-low one-hot column enable for column index idx (0 = column 1).
  function automatic logic [N_COL-1:0] col_sel_n(input logic [2:0] idx);
    col_sel_n = ~(5'b00001 << idx);
  endfunction

endpackage

// File: rtl/varredura_matriz.sv
// Column-scan driver for the 7x5 LED matrix with per-slot blanking and tear-free frame capture.
// Optional blink support is compiled in with `define BLINK_EN.
module varredura_matriz
  import varredura_matriz_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int DIV_W        = 16,
  parameter int BLINK_FRAMES = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_ROW-1:0] coluna1,
  input  logic [N_ROW-1:0] coluna2,
  input  logic [N_ROW-1:0] coluna3,
  input  logic [N_ROW-1:0] coluna4,
  input  logic [N_ROW-1:0] coluna5,
  input  logic             piscar,
  output logic [N_COL-1:0] col_n,
  output logic [N_ROW-1:0] linhas,
  output logic             frame_tick
);

  localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] CNT_BLANK = DIV_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'(N_COL - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  frame_t           s1_q, s2_q, shadow_q, shadow_d;
  logic [N_COL-1:0] col_n_q, col_n_d;
  logic [N_ROW-1:0] linhas_q, linhas_d;
  logic             frame_tick_q, frame_tick_d;
  logic             slot_end, boundary, stable, dark_d;
  logic [N_ROW-1:0] col_word [N_COL];

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign stable   = (s1_q == s2_q);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // A change in flight at the boundary makes s1 != s2, so a half-updated frame is never taken.
  assign shadow_d = (boundary && stable) ? s2_q : shadow_q;

  for (genvar gi = 0; gi < N_COL; gi++) begin : g_col
    assign col_word[gi] = shadow_d[gi*N_ROW +: N_ROW];
  end

`ifdef BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  logic              p1_q, p2_q, pslot_q, pslot_d, phase_q, phase_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (!p2_q) begin
        fcnt_d  = '0;
        phase_d = 1'b0;
      end else if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  // The blink request is only re-evaluated at slot starts so no slot is cut short.
  assign pslot_d = slot_end ? p2_q : pslot_q;
  assign dark_d  = pslot_d && phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      pslot_q <= 1'b0;
      phase_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      p1_q    <= piscar;
      p2_q    <= p1_q;
      pslot_q <= pslot_d;
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
    end
  end
`else
  logic unused_piscar;
  assign unused_piscar = piscar;
  assign dark_d        = 1'b0;
`endif

  // Outputs are decoded from next-state so the registered pins line up with cnt_q/idx_q.
  always_comb begin
    frame_tick_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
    col_n_d      = COL_OFF;
    linhas_d     = '0;
    if (!(cnt_d < CNT_BLANK) && !dark_d) begin
      col_n_d  = col_sel_n(idx_d);
      linhas_d = col_word[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      shadow_q     <= '0;
      col_n_q      <= COL_OFF;
      linhas_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      s1_q         <= {coluna5, coluna4, coluna3, coluna2, coluna1};
      s2_q         <= s1_q;
      shadow_q     <= shadow_d;
      col_n_q      <= col_n_d;
      linhas_q     <= linhas_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign col_n      = col_n_q;
  assign linhas     = linhas_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_varredura_matriz.sv
// Directed bench for varredura_matriz: scan order, frame capture, tear rejection, mid-scan reset, blink.
module tb_varredura_matriz;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FR = 5 * SD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] c1, c2, c3, c4, c5;
  logic       piscar;
  logic [4:0] col_n;
  logic [6:0] linhas;
  logic       frame_tick;

  varredura_matriz #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BL), .DIV_W(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coluna1(c1), .coluna2(c2), .coluna3(c3), .coluna4(c4), .coluna5(c5),
    .piscar(piscar), .col_n(col_n), .linhas(linhas), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic [34:0] vis, next_vis;
  int          fcnt_m;
  logic        phase_m, pslot_m;

  localparam logic [6:0] P1 = 7'b0111100, P2 = 7'b0011101, P3 = 7'b0110101,
                         P4 = 7'b1000111, P5 = 7'b1110111, Q3 = 7'b1010101;
  localparam logic [34:0] FRAME_P  = {P5, P4, P3, P2, P1};
  localparam logic [34:0] FRAME_P2 = {P5, P4, Q3, P2, P1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    int slot = (cyc / SD) % 5;
    int pos  = cyc % SD;
    logic [4:0] ec;
    logic [6:0] el;
    logic dark = 1'b0;
`ifdef BLINK_EN
    dark = pslot_m && phase_m;
`endif
    if (pos < BL || dark) begin
      ec = 5'b11111;
      el = 7'd0;
    end else begin
      ec = ~(5'b00001 << slot);
      el = vis[slot*7 +: 7];
    end
    check_val("col_n", 32'(col_n), 32'(ec));
    check_val("linhas", 32'(linhas), 32'(el));
    check_val("frame_tick", 32'(frame_tick), 32'((cyc % FR) == FR - 1));
    check_val("onehot", 32'($countones(~col_n) <= 1), 32'd1);
    check_val("off_dark", 32'((col_n == 5'b11111) && (linhas != 7'd0)), 32'd0);
  endtask

  task automatic tick();
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % FR == 0) begin
      if (!piscar) begin
        fcnt_m  = 0;
        phase_m = 1'b0;
      end else if (fcnt_m == 1) begin
        fcnt_m  = 0;
        phase_m = ~phase_m;
      end else begin
        fcnt_m++;
      end
      vis = next_vis;
      $display("[TB] frame start cyc=%0d shadow=%h", cyc, vis);
    end
    if (cyc % SD == 0) pslot_m = piscar;
  endtask

  task automatic restart_model(input logic [34:0] pending);
    cyc      = 0;
    vis      = 35'd0;
    next_vis = pending;
    fcnt_m   = 0;
    phase_m  = 1'b0;
    pslot_m  = 1'b0;
  endtask

  task automatic check_off(input string tag);
    check_val({tag, "_col_n"}, 32'(col_n), 32'h1f);
    check_val({tag, "_linhas"}, 32'(linhas), 32'd0);
    check_val({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    piscar = 1'b0;
    {c5, c4, c3, c2, c1} = 35'd0;
    restart_model(35'd0);
    repeat (3) @(posedge clk);
    #1;
    check_off("reset");

    rst_n = 1'b1;
    restart_model(35'd0);
    repeat (10) tick();

    {c5, c4, c3, c2, c1} = FRAME_P;
    next_vis = FRAME_P;
    while (cyc < 118) tick();

    // Change lands one cycle before the boundary: that load must be skipped.
    c3 = Q3;
    tick();
    while (cyc < 121) tick();
    next_vis = FRAME_P2;
    while (cyc < 180) tick();

    rst_n = 1'b0;
    #1;
    check_off("async_rst");
    @(posedge clk);
    #1;
    check_off("rst_hold");
    rst_n = 1'b1;
    restart_model(FRAME_P2);
    repeat (80) tick();

`ifdef BLINK_EN
    while (cyc < 84) tick();
    piscar = 1'b1;
    repeat (240) tick();
    piscar = 1'b0;
    repeat (80) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
